// File: rtl/display_multiplex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : display_multiplex                                               |
// | Purpose  : Sequential binary-to-BCD conversion of a signed or unsigned     |
// |            value, time-multiplexed onto NDIG active-low 7-segment digits.  |
// | Option   : DISPLAY_MUX_BLANK_ZEROS_EN blanks leading zeros and puts the    |
// |            minus sign next to the most significant digit.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module display_multiplex #(
  parameter int WIDTH    = 16,
  parameter int NDIG     = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             habilita,
  input  logic             carregar,
  input  logic             com_sinal,
  input  logic [WIDTH-1:0] valor,
  output logic             ocupado,
  output logic             pronto,
  output logic             estouro,
  output logic [6:0]       segmentos,
  output logic [NDIG-1:0]  anodos
);

  localparam int c_BCD = (WIDTH + 2) / 3 + 1;
  localparam int c_DW  = 4 * NDIG;
  localparam int c_CW  = $clog2(WIDTH + 1);
  localparam int c_PW  = $clog2(SCAN_DIV);
  localparam int c_IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [6:0] c_DASH  = 7'b1111110;
  localparam logic [6:0] c_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_bin;
  logic [4*c_BCD-1:0] r_bcd;
  logic [c_CW-1:0]    r_cnt;
  logic               r_neg_pend;
  logic [c_DW-1:0]    r_dig;
  logic               r_neg;
  logic               r_estouro;
  logic               r_ocupado;
  logic               r_pronto;
  logic [c_PW-1:0]    r_presc;
  logic [c_IW-1:0]    r_idx;
  logic [6:0]         r_seg;
  logic [NDIG-1:0]    r_an;

  logic               w_neg_in;
  logic [WIDTH-1:0]   w_mag;
  logic [4*c_BCD-1:0] w_bcd_adj;
  logic               w_ovf;
  logic [NDIG-1:0]    w_sel;
  logic [6:0]         w_glyph;
  int                 w_msd;

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    case (d)
      4'd0:    f_glyph = 7'b0000001;
      4'd1:    f_glyph = 7'b1001111;
      4'd2:    f_glyph = 7'b0010010;
      4'd3:    f_glyph = 7'b0000110;
      4'd4:    f_glyph = 7'b1001100;
      4'd5:    f_glyph = 7'b0100100;
      4'd6:    f_glyph = 7'b0100000;
      4'd7:    f_glyph = 7'b0001101;
      4'd8:    f_glyph = 7'b0000000;
      4'd9:    f_glyph = 7'b0000100;
      default: f_glyph = c_BLANK;
    endcase
  endfunction

  // WIDTH bits hold the magnitude of the most negative value when read as unsigned
  assign w_neg_in = com_sinal & valor[WIDTH-1];
  assign w_mag    = w_neg_in ? (~valor + {{(WIDTH-1){1'b0}}, 1'b1}) : valor;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int j = 0; j < c_BCD; j++) begin
      if (r_bcd[4*j +: 4] >= 4'd5) w_bcd_adj[4*j +: 4] = r_bcd[4*j +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_ovf = 1'b0;
    for (int j = 0; j < c_BCD; j++) begin
      if ((j >= (r_neg_pend ? NDIG - 1 : NDIG)) && (r_bcd[4*j +: 4] != 4'd0)) w_ovf = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (carregar) w_next = S_CONVERT;
      S_CONVERT: if (r_cnt == c_CW'(WIDTH - 1)) w_next = S_UPDATE;
      S_UPDATE:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_neg_pend <= 1'b0;
      r_dig      <= '0;
      r_neg      <= 1'b0;
      r_estouro  <= 1'b0;
      r_ocupado  <= 1'b0;
      r_pronto   <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (carregar) begin
            r_bin      <= w_mag;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_neg_pend <= w_neg_in;
            r_ocupado  <= 1'b1;
          end
        end
        S_CONVERT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 1'b1;
        end
        S_UPDATE: begin
          r_dig     <= c_DW'(r_bcd);
          r_neg     <= r_neg_pend;
          r_estouro <= w_ovf;
          r_pronto  <= 1'b1;
          r_ocupado <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_msd = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_dig[4*i +: 4] != 4'd0) w_msd = i;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_sel[i] = (r_idx == c_IW'(i));
    end
  end

  always_comb begin
    w_glyph = f_glyph(r_dig[4*r_idx +: 4]);
    if (r_estouro) begin
      w_glyph = c_DASH;
`ifdef DISPLAY_MUX_BLANK_ZEROS_EN
    end else if (int'(r_idx) > w_msd) begin
      w_glyph = (r_neg && (int'(r_idx) == w_msd + 1)) ? c_DASH : c_BLANK;
`else
    end else if (r_neg && (int'(r_idx) == NDIG - 1)) begin
      w_glyph = c_DASH;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_seg   <= c_BLANK;
      r_an    <= '1;
    end else begin
      if (r_presc == c_PW'(SCAN_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= (r_idx == c_IW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_seg <= habilita ? w_glyph : c_BLANK;
      r_an  <= habilita ? ~w_sel : '1;
    end
  end

  assign ocupado   = r_ocupado;
  assign pronto    = r_pronto;
  assign estouro   = r_estouro;
  assign segmentos = r_seg;
  assign anodos    = r_an;

endmodule
`default_nettype wire

// File: tb/tb_display_multiplex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_display_multiplex                                            |
// | Purpose  : Directed self-checking bench for display_multiplex               |
// |            (WIDTH=16, NDIG=5, SCAN_DIV=4); honours DISPLAY_MUX_BLANK_ZEROS_EN|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_display_multiplex;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        habilita  = 1'b1;
  logic        carregar  = 1'b0;
  logic        com_sinal = 1'b0;
  logic [15:0] valor     = '0;
  logic        ocupado;
  logic        pronto;
  logic        estouro;
  logic [6:0]  segmentos;
  logic [4:0]  anodos;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000;
  localparam logic [6:0] DASH = 7'b1111110, BLNK = 7'b1111111;
`ifdef DISPLAY_MUX_BLANK_ZEROS_EN
  localparam logic [6:0] LZ = BLNK;
  localparam bit BLANKING = 1'b1;
`else
  localparam logic [6:0] LZ = G0;
  localparam bit BLANKING = 1'b0;
`endif

  display_multiplex #(.WIDTH(16), .NDIG(5), .SCAN_DIV(4)) dut (
    .clock(clock), .reset_n(reset_n), .habilita(habilita), .carregar(carregar),
    .com_sinal(com_sinal), .valor(valor), .ocupado(ocupado), .pronto(pronto),
    .estouro(estouro), .segmentos(segmentos), .anodos(anodos)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [4:0] want, output bit found);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clock);
      if (anodos === want) found = 1'b1;
    end
  endtask

  task automatic read_digit(input int i, input logic [6:0] exp, input string tag);
    logic [4:0] want;
    bit found;
    want = ~(5'b00001 << i);
    wait_an(want, found);
    if (!found) chk({tag, "_timeout"}, {27'd0, anodos}, {27'd0, want});
    else        chk(tag, {25'd0, segmentos}, {25'd0, exp});
  endtask

  task automatic show5(input logic [6:0] g4, g3, g2, g1, g0, input string tag);
    read_digit(0, g0, {tag, "_d0"});
    read_digit(1, g1, {tag, "_d1"});
    read_digit(2, g2, {tag, "_d2"});
    read_digit(3, g3, {tag, "_d3"});
    read_digit(4, g4, {tag, "_d4"});
  endtask

  // Issues one load and checks busy length, pronto position and pronto count.
  task automatic do_load(input logic [15:0] v, input logic s, input int again_at, input string tag);
    int busy = 0, np = 0, pat = 0;
    @(negedge clock);
    valor = v; com_sinal = s; carregar = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n == 1) carregar = 1'b0;
      if (n == again_at) begin
        carregar = 1'b1; valor = 16'd999; com_sinal = 1'b0;
      end else if (n == again_at + 1) begin
        carregar = 1'b0;
      end
      if (ocupado === 1'b1) busy++;
      if (pronto === 1'b1) begin
        np++;
        if (pat == 0) pat = n;
      end
    end
    chk({tag, "_busy_cycles"}, busy, 17);
    chk({tag, "_pronto_at"}, pat, 18);
    chk({tag, "_pronto_count"}, np, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] exp100 [5];
    logic [4:0] want;
    bit found;
    int idx;

    repeat (3) @(negedge clock);
    chk("rst_seg", {25'd0, segmentos}, 32'h7F);
    chk("rst_an", {27'd0, anodos}, 32'h1F);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ocupado", {31'd0, ocupado}, 0);
    chk("rst_pronto", {31'd0, pronto}, 0);
    chk("rst_estouro", {31'd0, estouro}, 0);
    show5(LZ, LZ, LZ, LZ, G0, "rst");

    do_load(16'd1234, 1'b0, 0, "v1234");
    chk("v1234_estouro", {31'd0, estouro}, 0);
    show5(LZ, G1, G2, G3, G4, "v1234");

    // Scan sequence and 20-cycle wrap from the first cycle of digit 0
    wait_an(5'b01111, found);
    chk("scan_sync4", {31'd0, found}, 1);
    wait_an(5'b11110, found);
    chk("scan_sync0", {31'd0, found}, 1);
    for (int s = 1; s <= 5; s++) begin
      repeat (4) @(negedge clock);
      want = ~(5'b00001 << (s % 5));
      chk($sformatf("scan_step%0d", s), {27'd0, anodos}, {27'd0, want});
    end

    do_load(16'hFFD6, 1'b1, 0, "m42");
    chk("m42_estouro", {31'd0, estouro}, 0);
    if (BLANKING) show5(BLNK, BLNK, DASH, G4, G2, "m42");
    else          show5(DASH, G0, G0, G4, G2, "m42");

    do_load(16'h8000, 1'b1, 0, "m32768");
    chk("m32768_estouro", {31'd0, estouro}, 1);
    show5(DASH, DASH, DASH, DASH, DASH, "m32768");

    do_load(16'd65535, 1'b0, 0, "v65535");
    chk("v65535_estouro", {31'd0, estouro}, 0);
    show5(G6, G5, G5, G3, G5, "v65535");

    do_load(16'd100, 1'b0, 5, "v100");
    chk("v100_estouro", {31'd0, estouro}, 0);
    show5(LZ, LZ, G1, G0, G0, "v100");

    exp100[0] = G0; exp100[1] = G0; exp100[2] = G1; exp100[3] = LZ; exp100[4] = LZ;
    repeat (7) @(negedge clock);
    habilita = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      chk($sformatf("dis_seg%0d", n), {25'd0, segmentos}, 32'h7F);
      chk($sformatf("dis_an%0d", n), {27'd0, anodos}, 32'h1F);
    end
    habilita = 1'b1;
    @(negedge clock);
    chk("reen_onehot", $countones(~anodos), 1);
    idx = 0;
    for (int i = 0; i < 5; i++) if (anodos[i] === 1'b0) idx = i;
    chk("reen_seg", {25'd0, segmentos}, {25'd0, exp100[idx]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_multiplex.md
Name: display_multiplex

Overview:
- Parametrised successor to the single-digit 7-segment decoder.
- Accepts a WIDTH-bit binary value, which may be signed, and converts it sequentially to BCD (shift-add-3).
- Time-multiplexes NDIG digits onto one active-low segment bus plus active-low digit anodes.
- Sits between the CPU output register and the board's multiplexed 7-segment bank.

Parameters:
- WIDTH, 16, bit width of the input value.
- NDIG, 5, number of physical digits driven (1..8).
- SCAN_DIV, 50000, clock cycles each digit stays lit (>=2).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- habilita  input  1  display enable; 0 blanks segments and anodes.
- carregar  input  1  1-cycle request to convert valor.
- com_sinal  input  1  1 = valor is two's complement; 0 = unsigned. Sampled with carregar.
- valor  input  WIDTH  binary value to display. Sampled with carregar.
- ocupado  output  1  conversion in progress.
- pronto  output  1  1-cycle pulse when the new value is on the display.
- estouro  output  1  last converted value did not fit in NDIG digits.
- segmentos  output  7  active-low, bit6=a .. bit0=g.
- anodos  output  NDIG  active-low one-hot digit select; bit0 = rightmost digit.

Behaviour:
- Reset (reset_n=0 at a clock edge): segmentos=7'h7F, anodos=all 1, ocupado=0, pronto=0, estouro=0, display digit registers = value 0, scan index=0, prescaler=0, FSM=IDLE.
- Glyph encoding, active low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001101, 8=0000000, 9=0000100
  - dash=1111110, blank=1111111
- FSM states:
  - IDLE: carregar=1 latches valor and com_sinal. Magnitude = two's-complement negation if com_sinal & valor[WIDTH-1]; WIDTH bits is sufficient, including the most negative value. Sets ocupado=1, goes to CONVERT.
  - CONVERT: exactly WIDTH cycles. Each cycle adds 3 to every BCD nibble >=5, then shifts left one bit. Internal BCD width is ceil(WIDTH/3)+1 digits.
  - UPDATE: 1 cycle. Writes display registers, estouro and the negative flag atomically. Pulses pronto=1 and clears ocupado. Returns to IDLE.
- Timing: carregar sampled at edge k gives ocupado=1 after edge k, pronto=1 after edge k+WIDTH+1, and the new value visible from that cycle. Back-to-back loads: carregar may be reasserted in the cycle pronto=1.
- carregar while ocupado=1 is ignored. No queueing; the conversion in flight is unaffected.
- Overflow:
  - Available digits = NDIG, or NDIG-1 when negative.
  - If any BCD digit at index >= available is nonzero: estouro=1 and all NDIG digits show dash.
  - Otherwise estouro=0.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously, independent of habilita and the FSM.
  - At terminal count the scan index increments, wrapping NDIG-1 -> 0.
  - anodos has a 0 only at the scan index. segmentos carries that digit's glyph.
  - Both outputs are registered: 1-cycle latency from index change.
- habilita=0: segmentos=7'h7F and anodos=all 1 on the next edge. Scanning and conversion continue.
- Reset asserted mid-conversion aborts it: no pronto pulse, and the display reverts to 0.

Optional Feature:
- Macro DISPLAY_MUX_BLANK_ZEROS_EN.
- Defined:
  - Leading zeros above the most significant nonzero digit show blank. Digit 0 always shows a numeral.
  - For negative values the dash occupies the digit immediately left of the most significant nonzero digit.
- Undefined:
  - All digits show numerals, including leading zeros.
  - For negative values the dash occupies digit NDIG-1.
- Overflow display is identical in both builds.

Test Plan (WIDTH=16, NDIG=5, SCAN_DIV=4, blanking enabled unless stated):
- Reset held 3 cycles, then released -> segmentos=7'h7F and anodos=5'h1F during reset; after release, digit0 shows 0000001 and digits 1..4 show blank. ocupado=0, pronto=0, estouro=0.
- carregar with valor=1234, com_sinal=0 -> ocupado high 17 cycles, pronto pulse at edge k+17. Scan shows digit0..3 = 4,3,2,1 (1001100,0000110,0010010,1001111); digit4 blank; anodos cycles 11110,11101,11011,10111,01111, wrapping every 20 cycles.
- valor=16'hFFD6 (-42), com_sinal=1 -> digits 2,4 on digit0/1, dash on digit2, blank on digits 3/4. Blanking disabled: 0,0 on digits 2/3 and dash on digit4.
- valor=16'h8000 with com_sinal=1 (-32768), then 65535 with com_sinal=0 -> first: estouro=1, all digits dash. Second: estouro=0, shows 65535 with no blanks.
- carregar=1 again 5 cycles into a conversion of 100 -> ignored; exactly one pronto pulse, display shows 100.
- habilita=0 for 10 cycles mid-scan -> all outputs inactive-high from the next edge. Re-enable resumes at the current scan index with no glitch beyond the 1-cycle register latency.
